// File: rtl/mod_addsub_serial_pkg.sv
// Shared types and helpers for the bit-serial modular adder/subtractor.
package mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit-position counter width for an operand of w bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mod_addsub_serial_if.sv
// Request/result bundle for mod_addsub_serial; slave = the arithmetic block.
interface mod_addsub_serial_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] cand0;
  logic [WIDTH-1:0] cand1;
  logic             sel;
  logic [WIDTH-1:0] result;
  logic             err;

  modport slave (
    input  in_valid, op, a, b, m, out_ready,
    output in_ready, out_valid, cand0, cand1, sel, result, err
  );

  modport master (
    output in_valid, op, a, b, m, out_ready,
    input  in_ready, out_valid, cand0, cand1, sel, result, err
  );
endinterface

// File: rtl/mod_addsub_serial_fa.sv
// One-bit full adder with a registered carry; load seeds the carry.
module mod_serial_fa (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic cin_init,
  input  logic x,
  input  logic y,
  output logic sum
);
  logic c_q, c_d;

  always_comb begin
    sum = x ^ y ^ c_q;
    c_d = load ? cin_init : ((x & y) | (c_q & (x ^ y)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= 1'b0;
    else        c_q <= c_d;
  end
endmodule

// File: rtl/mod_addsub_serial.sv
// Bit-serial modular add/subtract: raw chain A±B and correction chain raw∓M,
// LSB-first, then a select cycle that picks the reduced candidate.
module mod_addsub_serial
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mod_addsub_serial_if.slave  bus
);
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] m_sh_q, m_sh_d;
  logic [WIDTH-1:0] cand0_q, cand0_d;
  logic [WIDTH-1:0] cand1_q, cand1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sel_q, sel_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic accept, shift, raw_bit, corr_bit, sel_calc;
  logic fa1_x, fa1_y, fa2_x, fa2_y;

  // Outside bit cycles each chain sees x=1,y=0: the carry holds and sum = ~carry,
  // which lets the select cycle read both final carries through the sum ports.
  always_comb begin
    accept = (state_q == IDLE) && bus.in_valid;
    shift  = (state_q == CALC) && !last_q;
    fa1_x  = shift ? a_sh_q[0] : 1'b1;
    fa1_y  = shift ? b_sh_q[0] : 1'b0;
    fa2_x  = shift ? raw_bit   : 1'b1;
    fa2_y  = shift ? m_sh_q[0] : 1'b0;
    // c1 = ~raw_bit, c2 = ~corr_bit here; sel = op ? ~c1 : (c1 | c2)
    sel_calc = (op_q == OP_SUB) ? raw_bit : ~(raw_bit & corr_bit);
  end

  mod_serial_fa u_raw_fa (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .cin_init (bus.op == OP_SUB),
    .x        (fa1_x),
    .y        (fa1_y),
    .sum      (raw_bit)
  );

  mod_serial_fa u_corr_fa (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .cin_init (bus.op == OP_ADD),
    .x        (fa2_x),
    .y        (fa2_y),
    .sum      (corr_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    m_sh_d      = m_sh_q;
    cand0_d     = cand0_q;
    cand1_d     = cand1_q;
    result_d    = result_q;
    sel_d       = sel_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d     = bus.a;
          b_sh_d     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
          m_sh_d     = (bus.op == OP_SUB) ? bus.m : ~bus.m;
          op_d       = bus.op;
          cnt_d      = '0;
          last_d     = 1'b0;
          err_d      = (bus.a >= bus.m) || (bus.b >= bus.m) || (bus.m < WIDTH'(2));
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (!last_q) begin
          cand0_d = {raw_bit, cand0_q[WIDTH-1:1]};
          cand1_d = {corr_bit, cand1_q[WIDTH-1:1]};
          a_sh_d  = a_sh_q >> 1;
          b_sh_d  = b_sh_q >> 1;
          m_sh_d  = m_sh_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) last_d = 1'b1;
        end else begin
          sel_d       = sel_calc;
          result_d    = sel_calc ? cand1_q : cand0_q;
          out_valid_d = 1'b1;
          last_d      = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      op_q        <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      m_sh_q      <= '0;
      cand0_q     <= '0;
      cand1_q     <= '0;
      result_q    <= '0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      m_sh_q      <= m_sh_d;
      cand0_q     <= cand0_d;
      cand1_q     <= cand1_d;
      result_q    <= result_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cand0     = cand0_q;
  assign bus.cand1     = cand1_q;
  assign bus.sel       = sel_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mod_addsub_serial.sv
// Directed bench for mod_addsub_serial at WIDTH=4 with hand-computed vectors
// and an exhaustive in-range sweep against a small arithmetic model.
module tb_mod_addsub_serial;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mod_addsub_serial_if #(.WIDTH(W)) bus ();

  mod_addsub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int op, input int a, input int b, input int m);
    @(negedge clk);
    bus.op       = op[0];
    bus.a        = 4'(a);
    bus.b        = 4'(b);
    bus.m        = 4'(m);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic run_chk(input string tag, input int op, input int a, input int b, input int m,
                         input int c0, input int c1, input int sl, input int rs, input int er);
    int lat;
    start(op, a, b, m);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_cand0"}, bus.cand0, c0);
    chk({tag, "_cand1"}, bus.cand1, c1);
    chk({tag, "_sel"}, bus.sel, sl);
    chk({tag, "_result"}, bus.result, rs);
    chk({tag, "_err"}, bus.err, er);
    handshake(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen, s, c0, c1, sl;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.m = '0;

    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cand0", bus.cand0, 0);
    chk("rst_cand1", bus.cand1, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_chk("add_7_9", 0, 7, 9, 11, 0, 5, 1, 5, 0);
    run_chk("add_3_4", 0, 3, 4, 11, 7, 12, 0, 7, 0);
    run_chk("sub_3_9", 1, 3, 9, 11, 10, 5, 1, 5, 0);
    run_chk("sub_9_3", 1, 9, 3, 11, 6, 1, 0, 6, 0);
    run_chk("err_12_1", 0, 12, 1, 11, 13, 2, 1, 2, 1);
    run_chk("err_m1", 0, 0, 0, 1, 0, 15, 0, 0, 1);

    // Backpressure with a competing request held high.
    start(0, 7, 9, 11);
    wait_valid(lat);
    chk("bp_latency", lat, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.op = 1'b0; bus.a = 4'd1; bus.b = 4'd2; bus.m = 4'd11;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_cand0", bus.cand0, 0);
      chk("bp_cand1", bus.cand1, 5);
      chk("bp_sel", bus.sel, 1);
      chk("bp_result", bus.result, 5);
    end
    handshake("bp_hs");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_accept_after", bus.in_ready, 0);
    wait_valid(lat);
    chk("bp2_latency", lat, 5);
    chk("bp2_cand0", bus.cand0, 3);
    chk("bp2_cand1", bus.cand1, 8);
    chk("bp2_sel", bus.sel, 0);
    chk("bp2_result", bus.result, 3);
    handshake("bp2_hs");

    // Reset in the middle of CALC abandons the operation.
    start(0, 5, 6, 11);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_result", bus.result, 0);
    chk("abort_cand0", bus.cand0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run_chk("add_5_5", 0, 5, 5, 11, 10, 15, 0, 10, 0);

    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 11; a++) begin
        for (int b = 0; b < 11; b++) begin
          if (op == 0) begin
            s  = a + b;
            c0 = s % 16;
            c1 = (s - 11 + 32) % 16;
            sl = (s >= 16 || c0 >= 11) ? 1 : 0;
          end else begin
            c0 = (a - b + 16) % 16;
            c1 = (a - b + 11 + 16) % 16;
            sl = (a < b) ? 1 : 0;
          end
          run_chk("sweep", op, a, b, 11, c0, c1, sl, sl ? c1 : c0, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_addsub_serial.md
Name: mod_addsub_serial

Overview:
- Bit-serial modular adder/subtractor that produces the candidate-pair plus select triple consumed by the second-stage selection mux.
- Computes the raw result (A±B) and the corrected result (raw∓M) LSB-first, one bit per clock, over WIDTH cycles.
- Derives the select bit from the final carries and presents cand0, cand1, sel and result under a valid/ready handshake.

Parameters:
- WIDTH, 4, operand/modulus width in bits (WIDTH ≥ 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block accepts an operand set.
- op  in  1  0 = add, 1 = subtract.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- m  in  WIDTH  modulus M.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts the result.
- cand0  out  WIDTH  raw candidate (A+B or A−B, low WIDTH bits).
- cand1  out  WIDTH  corrected candidate (raw−M for add, raw+M for subtract).
- sel  out  1  1 selects cand1.
- result  out  WIDTH  sel ? cand1 : cand0.
- err  out  1  operands out of range for the captured request.

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0 except in_ready = 1; counter, shift registers and carries cleared. Reset during CALC abandons the operation with no output.
- States: IDLE, CALC, DONE.
- IDLE: in_ready = 1.
  - On in_valid: latch a, b, m and op; counter = 0; go to CALC.
  - Initial carries for add: c1 = 0, c2 = 1 (because raw − M = raw + ~M + 1).
  - Initial carries for subtract: c1 = 1 (because A − B = A + ~B + 1), c2 = 0.
  - err is registered at accept: 1 if a ≥ m, b ≥ m or m < 2. The computation still runs.
- CALC: in_ready = 0. Each cycle i = 0..WIDTH−1:
  - raw bit r_i = a_i ^ b'_i ^ c1, where b' = op ? ~b : b; c1 updates to the carry-out.
  - corrected bit k_i = r_i ^ m'_i ^ c2, where m' = op ? m : ~m; c2 updates to the carry-out.
  - r_i and k_i shift into cand0 and cand1 from the MSB side, so after WIDTH shifts bit i sits at index i.
  - After bit WIDTH−1: sel = op ? ~c1 : (c1 | c2); result is registered; go to DONE.
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accepting edge (WIDTH bit cycles plus 1 select cycle).
- DONE: out_valid = 1; cand0, cand1, sel, result and err are held stable.
  - On out_ready: out_valid drops at that edge and the state returns to IDLE.
  - in_ready stays 0 in DONE, so a new request is accepted no earlier than the cycle after the handshake.
  - out_ready while not in DONE is ignored.
- Outputs hold their last values in IDLE until the next result is loaded; only out_valid marks them valid.
- All arithmetic is modulo 2^WIDTH; the carries supply the one extra bit.

Decomposition:
- Package mod_pkg holds:
  - state encoding IDLE/CALC/DONE;
  - OP_ADD = 0, OP_SUB = 1;
  - the counter width, $clog2(WIDTH).
- One sub-module, mod_serial_fa: a 1-bit full adder with a registered carry.
  - Ports: clk, rst_n, load, cin_init, x, y, sum.
  - Instantiated twice: the raw chain and the correction chain.

Test Plan (WIDTH = 4, M = 11):
- Add 7 + 9 -> after 5 edges: cand0 = 0, cand1 = 5, sel = 1, result = 5, err = 0.
- Add 3 + 4 -> cand0 = 7, cand1 = 12, sel = 0, result = 7.
- Subtract 3 − 9 -> cand0 = 10, cand1 = 5, sel = 1, result = 5. Subtract 9 − 3 -> cand0 = 6, cand1 = 1, sel = 0, result = 6.
- Backpressure: out_ready held low 3 cycles after out_valid -> all outputs stable; in_ready = 0; a new in_valid is ignored until 1 cycle after the handshake.
- Reset asserted at CALC bit 2, released, then add 5 + 5 issued -> out_valid never asserted for the aborted operation; the new operation returns result = 10, sel = 0.
- Add a = 12, b = 1 -> err = 1, result = 2 (computed by the same formula); an exhaustive sweep of all a, b < 11 with both ops matches the reference model.
